dbus_sram_wbuf: RTL
===================

Name: dbus_sram_wbuf

Overview:
Next-generation CPU data-bus bridge from the MEM-stage access port to the sram-like data interface.
- Adds a parametrised posted-write buffer, so stores retire without waiting for the bus.
- Loads are strictly ordered behind buffered stores; one bus transaction is outstanding at a time.
- Sits between the MEM stage and the sram-like-to-AXI converter.
- Drives the pipeline stall request and exposes a buffer-empty status for sync/cache operations.

Parameters:
- WBUF_DEPTH, 4: write-buffer entries; power of two, at least 2.
- STALL_W, 5: width of the pipeline stall vector.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets)
- stall_i  in  STALL_W  pipeline stall vector; any bit set means the pipeline is held
- flush_i  in  1  pipeline flush; blocks acceptance of a new access
- cpu_ce_i  in  1  access valid
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  word-aligned address
- cpu_data_i  in  32  store data, in byte lanes
- cpu_byteenable_i  in  4  byte-lane enables
- cpu_data_o  out  32  load result
- stallreq  out  1  bridge requests pipeline stall
- wbuf_empty_o  out  1  buffer empty and no write in flight
- data_req  out  1  sram-like request
- data_wr  out  1  sram-like write
- data_size  out  2  sram-like size
- data_addr  out  32  sram-like address
- data_wdata  out  32  sram-like write data
- data_rdata  in  32  sram-like read data
- data_addr_ok  in  1  sram-like address accepted
- data_data_ok  in  1  sram-like data returned / write acknowledged

Behaviour:
- Reset (reset==0 at a clock edge):
  - All registered outputs go to 0; stallreq=0; cpu_data_o=0.
  - Buffer empties; state goes to S_IDLE; wr_taken clears.
  - Reset mid-transaction abandons it; the interconnect is reset in the same cycle.
- Byte-enable decode, for both loads and stores:
  - 0001/0010/0100/1000 give size 0 and offset 0/1/2/3.
  - 0011 gives size 1, offset 0; 1100 gives size 1, offset 2.
  - All other patterns give size 2, offset 0.
  - Bus address = cpu_addr_i + offset.
- Store acceptance: cpu_ce_i & cpu_we_i & !flush_i & !full & !wr_taken.
  - Push {addr+offset, size, cpu_data_i} in the same cycle; stallreq=0 combinationally.
  - Then set wr_taken, which clears in the first cycle with stall_i==0. This prevents a double push while the pipeline is held by another stage.
  - Buffer full: stallreq=1 until a pop frees a slot. Push and pop in the same cycle are both honoured.
- Load: cpu_ce_i & !cpu_we_i & !flush_i, with stallreq=1 throughout.
  - While the buffer is non-empty or a write is in flight, the load waits (write drain first; no forwarding).
  - Once drained it issues from S_IDLE.
- FSM states: S_IDLE, S_WREQ, S_WRESP, S_RREQ, S_RRESP, S_RHOLD. The write path has priority in S_IDLE.
  - S_IDLE → S_WREQ when the buffer is non-empty. Registers the head entry onto data_addr/size/wdata; data_req=1, data_wr=1.
  - S_IDLE → S_RREQ when a load is pending and the buffer is empty (data_wr=0).
  - S_WREQ/S_RREQ: hold data_req until a cycle with data_addr_ok. The next edge drops data_req and data_wr, then goes to S_WRESP/S_RRESP.
  - If data_addr_ok and data_data_ok arrive in the same cycle, treat it as completion immediately.
  - S_WRESP: on data_data_ok, pop the head and return to S_IDLE.
  - S_RRESP: on data_data_ok, drive cpu_data_o=data_rdata with stallreq=0 that cycle, and capture rd_buf.
    - Next state is S_RHOLD if stall_i!=0, else S_IDLE.
  - S_RHOLD: cpu_data_o=rd_buf, stallreq=0; exit to S_IDLE when stall_i==0.
- Latency and throughput:
  - Store with a free slot: 0 stall cycles.
  - Load with an empty buffer and immediate oks: stallreq high 2 cycles (S_IDLE, S_RREQ), data returned in S_RRESP.
  - One bus transaction is outstanding at a time.
- flush_i: never cancels issued bus transactions or buffered stores (both are committed).
  - A load flushed after issue completes on the bus and its data is discarded: no S_RHOLD, return to S_IDLE.
- wbuf_empty_o = buffer empty & state not in {S_WREQ, S_WRESP}.
- cpu_data_o is 0 whenever no load result is presented.

Decomposition:
- dbus_pkg holds:
  - state enum;
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - the byte-enable→{size, offset} decode function;
  - the entry width constant (32+32+2).
- Sub-module dbus_wbuf_fifo:
  - synchronous FIFO, parameters DEPTH and WIDTH;
  - ports push/pop/full/empty/head;
  - pointers carry an extra wrap bit for full/empty disambiguation.

Test Plan:
- Store word 0x8000_0010 ← 0xDEADBEEF, be=1111, bus oks one cycle later → stallreq stays 0; data_addr=0x8000_0010, data_size=2, data_wr=1; wbuf_empty_o returns to 1 after data_data_ok.
- Five back-to-back stores with WBUF_DEPTH=4 and data_addr_ok held low → 5th store asserts stallreq until the first pop; all 5 appear on the bus in order.
- Store be=0100 to 0x100, then load 0x100 → load request appears only after the write's data_data_ok; address 0x102 size 0 for the store, 0x100 size 2 for the load.
- Load with data_data_ok while stall_i=5'b00100 → cpu_data_o holds rd_buf (0x12345678) in S_RHOLD until stall_i=0; exactly one bus read.
- Store presented for 3 cycles with stall_i≠0 → exactly one push.
- Load issued, then flush_i → bus read completes and result is discarded; reset=0 mid-S_WRESP → state S_IDLE, data_req=0, wbuf_empty_o=1.

Source files
------------

// File: rtl/dbus_pkg.sv
// ---------------------------------------------------------------------------
// dbus_pkg
// Shared definitions for the CPU data-bus bridge with posted-write buffer:
//   - state_t     : bridge FSM states
//   - SZ_*        : sram-like transfer size encodings
//   - ENTRY_W     : write-buffer entry width {addr[31:0], size[1:0], data[31:0]}
//   - be_decode() : byte-enable pattern to {size, byte offset}
// ---------------------------------------------------------------------------
package dbus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREQ,
        S_WRESP,
        S_RREQ,
        S_RRESP,
        S_RHOLD
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int ENTRY_W = 32 + 32 + 2;

    typedef struct packed {
        logic [1:0] size;
        logic [1:0] offset;
    } be_dec_t;

    // Single lanes become byte accesses, aligned lane pairs become halfwords,
    // anything else is issued as a full word.
    function automatic be_dec_t be_decode(input logic [3:0] be);
        be_dec_t d;
        d.size   = SZ_WORD;
        d.offset = 2'd0;
        case (be)
            4'b0001: begin d.size = SZ_BYTE; d.offset = 2'd0; end
            4'b0010: begin d.size = SZ_BYTE; d.offset = 2'd1; end
            4'b0100: begin d.size = SZ_BYTE; d.offset = 2'd2; end
            4'b1000: begin d.size = SZ_BYTE; d.offset = 2'd3; end
            4'b0011: begin d.size = SZ_HALF; d.offset = 2'd0; end
            4'b1100: begin d.size = SZ_HALF; d.offset = 2'd2; end
            default: begin d.size = SZ_WORD; d.offset = 2'd0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dbus_sram_wbuf_if.sv
// ---------------------------------------------------------------------------
// dbus_sram_wbuf_if
// sram-like data interface between the bridge (master) and the
// sram-like-to-AXI converter (slave).
//   data_req/data_wr/data_size/data_addr/data_wdata : master -> slave
//   data_rdata/data_addr_ok/data_data_ok            : slave  -> master
// ---------------------------------------------------------------------------
interface dbus_sram_wbuf_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok
    );

endinterface

// File: rtl/dbus_wbuf_fifo.sv
// ---------------------------------------------------------------------------
// dbus_wbuf_fifo
// Synchronous FIFO holding posted stores.
//   clock, reset     : clock, synchronous active-low reset
//   push, push_data  : write an entry (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   full, empty      : occupancy status
//   head             : oldest entry, valid while !empty
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module dbus_wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset; only entries between the pointers are read.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dbus_sram_wbuf.sv
// ---------------------------------------------------------------------------
// dbus_sram_wbuf
// MEM-stage data-bus bridge to the sram-like interface with a posted-write
// buffer. Stores retire into the buffer; loads wait until the buffer has
// drained, then issue. One bus transaction is outstanding at a time.
//   clock, reset      : clock, synchronous active-low reset
//   stall_i, flush_i  : pipeline hold vector and flush
//   cpu_*_i           : MEM-stage access (ce, we, addr, data, byteenable)
//   cpu_data_o        : load result, 0 when no result is presented
//   stallreq          : bridge asks the pipeline to hold
//   wbuf_empty_o      : no buffered store and no write on the bus
//   bus               : sram-like master port
// ---------------------------------------------------------------------------
module dbus_sram_wbuf
    import dbus_pkg::*;
#(
    parameter int WBUF_DEPTH = 4,
    parameter int STALL_W    = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_data_i,
    input  logic [3:0]         cpu_byteenable_i,
    output logic [31:0]        cpu_data_o,
    output logic               stallreq,
    output logic               wbuf_empty_o,
    dbus_sram_wbuf_if.master   bus
);

    state_t state, state_n;

    logic        req_q, req_n;
    logic        wr_q, wr_n;
    logic [1:0]  size_q, size_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic        wr_taken;
    logic        rd_kill, rd_kill_n;
    logic [31:0] rd_buf;

    logic               stall_any;
    logic               store_req;
    logic               load_req;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] push_entry;
    be_dec_t            dec;
    logic [31:0]        cpu_bus_addr;
    logic               rd_complete;
    logic               rd_done;

    assign stall_any    = |stall_i;
    assign store_req    = cpu_ce_i & cpu_we_i & ~flush_i;
    assign load_req     = cpu_ce_i & ~cpu_we_i & ~flush_i;
    assign dec          = be_decode(cpu_byteenable_i);
    assign cpu_bus_addr = cpu_addr_i + {30'd0, dec.offset};
    assign push_entry   = {cpu_bus_addr, dec.size, cpu_data_i};

    // wr_taken blocks a second push of the same store while another stage
    // holds the pipeline.
    assign push = reset & store_req & ~fifo_full & ~wr_taken;

    dbus_wbuf_fifo #(
        .DEPTH (WBUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_comb begin
        state_n     = state;
        req_n       = req_q;
        wr_n        = wr_q;
        size_n      = size_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        pop         = 1'b0;
        rd_complete = 1'b0;
        rd_done     = 1'b0;
        // A flush while our read is on the bus marks its data as unwanted.
        rd_kill_n   = rd_kill | (flush_i & ((state == S_RREQ) | (state == S_RRESP)));

        case (state)
            S_IDLE: begin
                rd_kill_n = 1'b0;
                if (!fifo_empty) begin
                    state_n = S_WREQ;
                    req_n   = 1'b1;
                    wr_n    = 1'b1;
                    addr_n  = fifo_head[65:34];
                    size_n  = fifo_head[33:32];
                    wdata_n = fifo_head[31:0];
                end else if (load_req) begin
                    state_n = S_RREQ;
                    req_n   = 1'b1;
                    wr_n    = 1'b0;
                    addr_n  = cpu_bus_addr;
                    size_n  = dec.size;
                    wdata_n = 32'd0;
                end
            end
            S_WREQ: begin
                if (bus.data_addr_ok) begin
                    req_n = 1'b0;
                    wr_n  = 1'b0;
                    if (bus.data_data_ok) begin
                        pop     = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                if (bus.data_data_ok) begin
                    pop     = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_RREQ: begin
                if (bus.data_addr_ok) begin
                    req_n = 1'b0;
                    wr_n  = 1'b0;
                    if (bus.data_data_ok) begin
                        rd_complete = 1'b1;
                    end else begin
                        state_n = S_RRESP;
                    end
                end
            end
            S_RRESP: begin
                if (bus.data_data_ok) begin
                    rd_complete = 1'b1;
                end
            end
            S_RHOLD: begin
                if (!stall_any) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // A discarded read returns straight to idle and never presents data.
        if (rd_complete) begin
            if (load_req && !rd_kill_n) begin
                rd_done = 1'b1;
                state_n = stall_any ? S_RHOLD : S_IDLE;
            end else begin
                state_n = S_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            wr_taken <= 1'b0;
            rd_kill  <= 1'b0;
            rd_buf   <= 32'd0;
        end else begin
            state    <= state_n;
            req_q    <= req_n;
            wr_q     <= wr_n;
            size_q   <= size_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            wr_taken <= (push | wr_taken) & stall_any;
            rd_kill  <= rd_kill_n;
            if (rd_done) begin
                rd_buf <= bus.data_rdata;
            end
        end
    end

    always_comb begin
        stallreq   = 1'b0;
        cpu_data_o = 32'd0;
        if (reset) begin
            stallreq = (load_req & ~(rd_done | (state == S_RHOLD)))
                     | (store_req & fifo_full & ~wr_taken);
            if (rd_done) begin
                cpu_data_o = bus.data_rdata;
            end else if (state == S_RHOLD) begin
                cpu_data_o = rd_buf;
            end
        end
    end

    assign wbuf_empty_o = fifo_empty & (state != S_WREQ) & (state != S_WRESP);

    assign bus.data_req   = req_q;
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;

endmodule
